// File: rtl/rsf_share_arb.sv
// rsf_share_arb: round-robin share of one 48-bit arithmetic right shifter
// between NUM_REQ requesters. Two register stages (operand, result) with
// valid/ready backpressure. Each result is tagged with its requester index.
module rsf_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*48-1:0]   req_data,
  input  logic [NUM_REQ*5-1:0]    req_shamt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [47:0]             out_data,
  output logic [ID_W-1:0]         out_id
);

  // per-lane operand views of the flat request buses
  logic [NUM_REQ-1:0][47:0] lane_data;
  logic [NUM_REQ-1:0][4:0]  lane_shamt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi]  = req_data[48*gi +: 48];
      assign lane_shamt[gi] = req_shamt[5*gi +: 5];
    end
  endgenerate

  // S1 operand register
  logic            s1_valid;
  logic [47:0]     s1_data;
  logic [4:0]      s1_shamt;
  logic [ID_W-1:0] s1_id;

  logic [ID_W-1:0] rr_ptr;
  logic            s1_en, s2_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            xfer;
  logic [47:0]     shr;

  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;

  // round-robin scan starting at rr_ptr; first valid requester wins
  always_comb begin
    int j;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
  end

  // grants are only offered when S1 can take the operand
  assign req_ready = (s1_en && !rst) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  // the shared shifter, fed from S1
  assign shr = 48'($signed(s1_data) >>> s1_shamt);

  // pipeline registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_shamt  <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= shr;
          out_id   <= s1_id;
        end
      end
      if (s1_en) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_data  <= lane_data[gnt_id];
          s1_shamt <= lane_shamt[gnt_id];
          s1_id    <= gnt_id;
        end
      end
      if (xfer)
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_rsf_share_arb.sv
// Directed bench for rsf_share_arb with hand-computed expected values.
module tb_rsf_share_arb;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*48-1:0]  req_data;
  logic [N*5-1:0]   req_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_data;
  logic [1:0]       out_id;

  int total = 0;
  int bad   = 0;

  logic [47:0] rr_d [N];
  logic [4:0]  rr_s [N];
  logic [47:0] rr_e [N];

  rsf_share_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shamt(req_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [47:0] d, input logic [4:0] s);
    req_data[48*i +: 48] = d;
    req_shamt[5*i +: 5]  = s;
  endtask

  initial begin
    rr_d[0] = 48'h0000_0000_1000; rr_s[0] = 5'd4; rr_e[0] = 48'h0000_0000_0100;
    rr_d[1] = 48'hFFFF_FFFF_FF00; rr_s[1] = 5'd4; rr_e[1] = 48'hFFFF_FFFF_FFF0;
    rr_d[2] = 48'h0000_1234_5678; rr_s[2] = 5'd8; rr_e[2] = 48'h0000_0012_3456;
    rr_d[3] = 48'h8000_0000_0000; rr_s[3] = 5'd1; rr_e[3] = 48'hC000_0000_0000;

    rst = 1'b1; req_valid = '1; out_ready = 1'b1; req_data = '0; req_shamt = '0;
    tick();

    // 1. reset: nothing granted, nothing out; first grant after release -> 0
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_ready", 48'(req_ready), 48'h0);
      chk("rst_ovalid", 48'(out_valid), 48'h0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("first_grant", 48'(req_ready), 48'h1);
    chk("rst_odata", out_data, 48'h0);
    req_valid = '0;
    tick();

    // 2. single request from lane 2, latency 2
    set_lane(2, 48'h0000_0000_1000, 5'd4);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 48'(req_ready), 48'h4);
    tick();
    req_valid = '0;
    #1;
    chk("single_t1_valid", 48'(out_valid), 48'h0);
    tick();
    chk("single_t2_valid", 48'(out_valid), 48'h1);
    chk("single_data", out_data, 48'h0000_0000_0100);
    chk("single_id", 48'(out_id), 48'h2);
    tick();
    chk("single_drain", 48'(out_valid), 48'h0);

    // 3. sign and shift-amount boundaries, back-to-back from lane 1
    set_lane(1, 48'h8000_0000_0000, 5'd31);
    req_valid = 4'b0010;
    #1;
    chk("bnd_ready_a", 48'(req_ready), 48'h2);
    tick();
    set_lane(1, 48'hFFFF_FFFF_FFFF, 5'd31);
    #1;
    chk("bnd_ready_b", 48'(req_ready), 48'h2);
    tick();
    chk("bnd_neg31", out_data, 48'hFFFF_FFFF_0000);
    chk("bnd_id", 48'(out_id), 48'h1);
    set_lane(1, 48'h7FFF_FFFF_FFFF, 5'd0);
    #1;
    chk("bnd_ready_c", 48'(req_ready), 48'h2);
    tick();
    chk("bnd_m1_31", out_data, 48'hFFFF_FFFF_FFFF);
    req_valid = '0;
    tick();
    chk("bnd_pass0", out_data, 48'h7FFF_FFFF_FFFF);
    chk("bnd_pass0_v", 48'(out_valid), 48'h1);
    tick();
    chk("bnd_drain", 48'(out_valid), 48'h0);

    // move the pointer to 0 via a lone lane-3 request (pointer was 2)
    set_lane(3, 48'h0000_0000_00F0, 5'd4);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 48'(req_ready), 48'h8);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_data", out_data, 48'h0000_0000_000F);
    chk("wrap_id", 48'(out_id), 48'h3);

    // 4. round-robin with all lanes valid, one result per cycle
    for (int i = 0; i < N; i++) set_lane(i, rr_d[i], rr_s[i]);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk($sformatf("rr_ready_%0d", k), 48'(req_ready), 48'(1 << (k % N)));
      if (k >= 2) begin
        chk($sformatf("rr_ovalid_%0d", k), 48'(out_valid), 48'h1);
        chk($sformatf("rr_id_%0d", k), 48'(out_id), 48'((k - 2) % N));
        chk($sformatf("rr_data_%0d", k), out_data, rr_e[(k - 2) % N]);
      end
      tick();
    end
    chk("rr_drain", 48'(out_valid), 48'h0);

    // 5. backpressure: exactly two accepts, then stall with stable output
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("bp_ready0", 48'(req_ready), 48'h1);
    tick();
    chk("bp_ready1", 48'(req_ready), 48'h2);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_stall_ready_%0d", c), 48'(req_ready), 48'h0);
      chk($sformatf("bp_stall_v_%0d", c), 48'(out_valid), 48'h1);
      chk($sformatf("bp_stall_id_%0d", c), 48'(out_id), 48'h0);
      chk($sformatf("bp_stall_d_%0d", c), out_data, rr_e[0]);
      tick();
    end
    out_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_drain0_id", 48'(out_id), 48'h0);
    tick();
    chk("bp_drain1_v", 48'(out_valid), 48'h1);
    chk("bp_drain1_id", 48'(out_id), 48'h1);
    chk("bp_drain1_d", out_data, rr_e[1]);
    tick();
    chk("bp_drain_end", 48'(out_valid), 48'h0);

    // 6. reset with both stages full drops everything
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("mr_ready0", 48'(req_ready), 48'h4);
    tick();
    chk("mr_ready1", 48'(req_ready), 48'h8);
    tick();
    chk("mr_full_v", 48'(out_valid), 48'h1);
    chk("mr_full_id", 48'(out_id), 48'h2);
    rst = 1'b1;
    #1;
    chk("mr_rst_ready", 48'(req_ready), 48'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mr_no_out_%0d", c), 48'(out_valid), 48'h0);
      tick();
    end
    req_valid = 4'hF;
    #1;
    chk("mr_ptr0", 48'(req_ready), 48'h1);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
